// File: rtl/sw_debounce_if.sv
// sw_debounce_if: switch inputs and debounced outputs/pulses of sw_debounce.
interface sw_debounce_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic             sw_changed;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  modport master (output sw_in, input sw_out, sw_changed, sw_rise, sw_fall);
  modport slave  (input sw_in, output sw_out, sw_changed, sw_rise, sw_fall);
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: per-channel 2-flop sync + stable-count debouncer with change pulse.
// Define SW_DEBOUNCE_EDGE_EN to get registered per-channel rise/fall pulses.
module sw_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 450000
) (
  input logic          sys_clk,
  input logic          reset,
  sw_debounce_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {STABLE, PENDING} state_t;
  logic [WIDTH-1:0] r_s1, r_s2;
  logic [WIDTH-1:0] w_out, w_upd;
  logic             r_changed;
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_changed <= 1'b0;
    end else begin
      r_s1      <= bus.sw_in;
      r_s2      <= r_s1;
      r_changed <= |w_upd;
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_out;
    // an update happens only once the mismatch has been seen DEBOUNCE_CYCLES times in a row
    assign w_upd[i] = (r_state == PENDING) && (r_s2[i] != r_out) && (r_cnt == CMAX);
    assign w_out[i] = r_out;
    always_ff @(posedge sys_clk) begin
      if (reset) begin
        r_state <= STABLE;
        r_cnt   <= '0;
        r_out   <= 1'b0;
      end else if (r_state == STABLE) begin
        if (r_s2[i] != r_out) begin
          r_state <= PENDING;
          r_cnt   <= r_cnt + 1'b1;
        end
      end else if (r_s2[i] == r_out) begin
        r_state <= STABLE;
        r_cnt   <= '0;
      end else if (r_cnt == CMAX) begin
        r_out   <= r_s2[i];
        r_cnt   <= '0;
        r_state <= STABLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign bus.sw_out     = w_out;
  assign bus.sw_changed = r_changed;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise, r_fall;
  always_ff @(posedge sys_clk) begin
    r_rise <= reset ? '0 : w_upd & r_s2;
    r_fall <= reset ? '0 : w_upd & ~r_s2;
  end
  assign bus.sw_rise = r_rise;
  assign bus.sw_fall = r_fall;
`else
  assign bus.sw_rise = '0;
  assign bus.sw_fall = '0;
`endif
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed checks of sw_debounce with WIDTH=8, DEBOUNCE_CYCLES=4.
module tb_sw_debounce;
  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  sw_debounce_if #(.WIDTH(8)) bus ();
  sw_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // sw_in already applied; edges 0..4 hold old value, edge 5 shows new one
  task automatic run_update(input string tag, input logic [7:0] old_v, input logic [7:0] new_v);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk({tag, "_hold"}, bus.sw_out, old_v);
      chk({tag, "_chg_lo"}, bus.sw_changed, 0);
      chk({tag, "_rise_lo"}, bus.sw_rise, 0);
      chk({tag, "_fall_lo"}, bus.sw_fall, 0);
    end
    tick();
    chk({tag, "_upd"}, bus.sw_out, new_v);
    chk({tag, "_chg_hi"}, bus.sw_changed, 1);
    chk({tag, "_rise"}, bus.sw_rise, EDGE ? new_v & ~old_v : 8'h00);
    chk({tag, "_fall"}, bus.sw_fall, EDGE ? old_v & ~new_v : 8'h00);
    tick();
    chk({tag, "_after"}, bus.sw_out, new_v);
    chk({tag, "_chg_end"}, bus.sw_changed, 0);
    chk({tag, "_rise_end"}, bus.sw_rise, 0);
    chk({tag, "_fall_end"}, bus.sw_fall, 0);
  endtask
  initial begin
    bus.sw_in = 8'hFF;
    reset     = 1'b1;
    tick();
    tick();
    chk("rst_out", bus.sw_out, 8'h00);
    chk("rst_chg", bus.sw_changed, 0);
    chk("rst_rise", bus.sw_rise, 0);
    chk("rst_fall", bus.sw_fall, 0);
    reset = 1'b0;
    run_update("up_ff", 8'h00, 8'hFF);
    bus.sw_in = 8'h0F;
    run_update("dn_0f", 8'hFF, 8'h0F);
    bus.sw_in = 8'h00;
    for (int k = 0; k < 7; k++) tick();
    chk("settle_00", bus.sw_out, 8'h00);
    bus.sw_in = 8'hA5;
    run_update("up_a5", 8'h00, 8'hA5);
    bus.sw_in = 8'h00;
    for (int k = 0; k < 7; k++) tick();
    chk("settle_00b", bus.sw_out, 8'h00);
    // bit 3 high for three sampled edges: three synchronized cycles, one short of debounce
    bus.sw_in = 8'h08;
    for (int k = 0; k < 3; k++) tick();
    bus.sw_in = 8'h00;
    for (int k = 0; k < 10; k++) begin
      chk("glitch_out", bus.sw_out, 8'h00);
      chk("glitch_chg", bus.sw_changed, 0);
      chk("glitch_rise", bus.sw_rise, 0);
      tick();
    end
    // bit 0 pending with cnt=2 after edge 3, then one reset edge
    bus.sw_in = 8'h01;
    for (int k = 0; k < 4; k++) tick();
    chk("pend_out", bus.sw_out, 8'h00);
    reset = 1'b1;
    tick();
    chk("midrst_out", bus.sw_out, 8'h00);
    chk("midrst_chg", bus.sw_changed, 0);
    reset = 1'b0;
    run_update("rst_rel", 8'h00, 8'h01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
